reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 150 +++++++++++++++
 tb/tb_reorder_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation from rename, out-of-order writeback from execute,
// and in-order commit of up to WIDTH entries per cycle to RAT/ARF.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 2,
  localparam int ID_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           alloc_valid,
  input  logic [WIDTH-1:0][4:0]      alloc_dst,
  input  logic [WIDTH-1:0][63:0]     alloc_pc,
  output logic                       alloc_ready,
  output logic [WIDTH-1:0][ID_W-1:0] alloc_id,
  input  logic [1:0]                 wb_valid,
  input  logic [1:0][ID_W-1:0]       wb_id,
  input  logic [1:0][63:0]           wb_data,
  input  logic [3:0][ID_W-1:0]       rd_id,
  output logic [3:0][63:0]           rd_data,
  output logic [3:0]                 rd_done,
  output logic [WIDTH-1:0]           retire_valid,
  output logic [WIDTH-1:0][4:0]      retire_dst,
  output logic [WIDTH-1:0][63:0]     retire_data,
  output logic [WIDTH-1:0][63:0]     retire_pc,
  output logic [ID_W:0]              count
);

  logic [ID_W-1:0] head;
  logic [ID_W-1:0] tail;
  logic [DEPTH-1:0] entryValid;
  logic [DEPTH-1:0] entryDone;
  logic [4:0]  entryDst  [DEPTH];
  logic [63:0] entryPc   [DEPTH];
  logic [63:0] entryData [DEPTH];

  logic [WIDTH-1:0][ID_W-1:0] allocIdx;
  logic [WIDTH-1:0][ID_W-1:0] retireIdx;
  logic [WIDTH-1:0]           retireLane;
  logic [ID_W:0]              allocCnt;
  logic [ID_W:0]              allocTaken;
  logic [ID_W:0]              retireCnt;
  logic                       retireChain;

  // Readiness looks only at the registered count, so a same-cycle commit never opens room.
  assign alloc_ready = (count <= (ID_W+1)'(DEPTH - WIDTH));
  assign alloc_id    = allocIdx;
  assign allocTaken  = alloc_ready ? allocCnt : '0;

  // Valid lanes take consecutive ids starting at tail, in lane order.
  always_comb begin
    allocCnt = '0;
    allocIdx = '0;
    for (int k = 0; k < WIDTH; k++) begin
      allocIdx[k] = tail + allocCnt[ID_W-1:0];
      allocCnt    = allocCnt + (ID_W+1)'(alloc_valid[k]);
    end
  end

  // A lane may commit only if every older lane commits in the same cycle.
  always_comb begin
    retireChain = 1'b1;
    retireCnt   = '0;
    retireIdx   = '0;
    retireLane  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      retireIdx[k]  = head + ID_W'(k);
      retireLane[k] = retireChain & entryValid[retireIdx[k]] & entryDone[retireIdx[k]];
      retireChain   = retireLane[k];
      retireCnt     = retireCnt + (ID_W+1)'(retireLane[k]);
    end
  end

  // Operand reads see a same-cycle writeback; port 1 is evaluated last so it wins.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rd_done[r] = entryDone[rd_id[r]];
      rd_data[r] = entryData[rd_id[r]];
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && entryValid[wb_id[p]] && (wb_id[p] == rd_id[r])) begin
          rd_done[r] = 1'b1;
          rd_data[r] = wb_data[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      entryValid   <= '0;
      entryDone    <= '0;
      retire_valid <= '0;
      retire_dst   <= '0;
      retire_data  <= '0;
      retire_pc    <= '0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      entryValid   <= '0;
      entryDone    <= '0;
      retire_valid <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && entryValid[wb_id[p]]) begin
          entryDone[wb_id[p]] <= 1'b1;
        end
      end
      for (int k = 0; k < WIDTH; k++) begin
        retire_valid[k] <= retireLane[k];
        if (retireLane[k]) begin
          retire_dst[k]            <= entryDst[retireIdx[k]];
          retire_data[k]           <= entryData[retireIdx[k]];
          retire_pc[k]             <= entryPc[retireIdx[k]];
          entryValid[retireIdx[k]] <= 1'b0;
          entryDone[retireIdx[k]]  <= 1'b0;
        end
      end
      // Allocated slots are always free, so they never collide with retiring ones.
      for (int k = 0; k < WIDTH; k++) begin
        if (alloc_ready && alloc_valid[k]) begin
          entryValid[allocIdx[k]] <= 1'b1;
          entryDone[allocIdx[k]]  <= 1'b0;
        end
      end
      head  <= head + retireCnt[ID_W-1:0];
      tail  <= tail + allocTaken[ID_W-1:0];
      count <= count + allocTaken - retireCnt;
    end
  end

  // Payload storage needs no reset; the valid/done bits qualify its contents.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (wb_valid[p] && entryValid[wb_id[p]]) begin
        entryData[wb_id[p]] <= wb_data[p];
      end
    end
    for (int k = 0; k < WIDTH; k++) begin
      if (alloc_ready && alloc_valid[k]) begin
        entryDst[allocIdx[k]] <= alloc_dst[k];
        entryPc[allocIdx[k]]  <= alloc_pc[k];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic
// compared every cycle against an age-ordered queue model of the ROB.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int WIDTH = 2;
  localparam int ID_W  = 4;

  logic                       clk;
  logic                       reset;
  logic                       flush;
  logic [WIDTH-1:0]           alloc_valid;
  logic [WIDTH-1:0][4:0]      alloc_dst;
  logic [WIDTH-1:0][63:0]     alloc_pc;
  logic                       alloc_ready;
  logic [WIDTH-1:0][ID_W-1:0] alloc_id;
  logic [1:0]                 wb_valid;
  logic [1:0][ID_W-1:0]       wb_id;
  logic [1:0][63:0]           wb_data;
  logic [3:0][ID_W-1:0]       rd_id;
  logic [3:0][63:0]           rd_data;
  logic [3:0]                 rd_done;
  logic [WIDTH-1:0]           retire_valid;
  logic [WIDTH-1:0][4:0]      retire_dst;
  logic [WIDTH-1:0][63:0]     retire_data;
  logic [WIDTH-1:0][63:0]     retire_pc;
  logic [ID_W:0]              count;

  reorder_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
    .rd_id(rd_id), .rd_data(rd_data), .rd_done(rd_done),
    .retire_valid(retire_valid), .retire_dst(retire_dst),
    .retire_data(retire_data), .retire_pc(retire_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  dst;
    logic [63:0] pc;
    bit          done;
    logic [63:0] data;
  } entry_t;

  // Model: entries oldest-first, next id to hand out, and the registered retire outputs.
  entry_t                q[$];
  int                    mTail;
  logic [WIDTH-1:0]      mRetValid;
  logic [WIDTH-1:0][4:0] mRetDst;
  logic [WIDTH-1:0][63:0] mRetData;
  logic [WIDTH-1:0][63:0] mRetPc;

  int  checkCount = 0;
  int  passCount  = 0;
  bit  checking   = 1'b0;

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  function automatic int findIdx(int id);
    for (int i = 0; i < q.size(); i++)
      if (q[i].id == id) return i;
    return -1;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    int     nret;
    int     idx;
    bit     rdy;
    entry_t e;
    if (reset) begin
      q.delete();
      mTail     = 0;
      mRetValid = '0;
      mRetDst   = '0;
      mRetData  = '0;
      mRetPc    = '0;
    end else if (flush) begin
      q.delete();
      mTail     = 0;
      mRetValid = '0;
    end else begin
      rdy  = (q.size() <= DEPTH - WIDTH);
      nret = 0;
      for (int k = 0; k < WIDTH; k++)
        if (nret == k && q.size() > k && q[k].done) nret++;
      mRetValid = '0;
      for (int k = 0; k < nret; k++) begin
        mRetValid[k] = 1'b1;
        mRetDst[k]   = q[k].dst;
        mRetData[k]  = q[k].data;
        mRetPc[k]    = q[k].pc;
      end
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p]) begin
          idx = findIdx(int'(wb_id[p]));
          if (idx >= 0) begin
            e      = q[idx];
            e.done = 1'b1;
            e.data = wb_data[p];
            q[idx] = e;
          end
        end
      end
      repeat (nret) void'(q.pop_front());
      if (rdy) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (alloc_valid[k]) begin
            e.id   = mTail;
            e.dst  = alloc_dst[k];
            e.pc   = alloc_pc[k];
            e.done = 1'b0;
            e.data = '0;
            q.push_back(e);
            mTail = (mTail + 1) % DEPTH;
          end
        end
      end
    end
  endtask

  // Compare every DUT output with what the model says it must be right now.
  task automatic checkOutput();
    int          n;
    int          idx;
    bit          hit;
    logic [63:0] d;
    checkVal("count", count, q.size());
    checkVal("countBound", count <= DEPTH, 1);
    checkVal("allocReady", alloc_ready, q.size() <= DEPTH - WIDTH);
    n = 0;
    for (int k = 0; k < WIDTH; k++) begin
      if (alloc_valid[k]) begin
        checkVal("allocId", alloc_id[k], (mTail + n) % DEPTH);
        n++;
      end
    end
    for (int r = 0; r < 4; r++) begin
      idx = findIdx(int'(rd_id[r]));
      if (idx < 0) begin
        checkVal("rdDoneInvalid", rd_done[r], 0);
      end else begin
        hit = 1'b0;
        d   = '0;
        for (int p = 0; p < 2; p++) begin
          if (wb_valid[p] && wb_id[p] == rd_id[r]) begin
            hit = 1'b1;
            d   = wb_data[p];
          end
        end
        if (hit) begin
          checkVal("rdDoneBypass", rd_done[r], 1);
          checkVal("rdDataBypass", rd_data[r], d);
        end else begin
          checkVal("rdDone", rd_done[r], q[idx].done);
          if (q[idx].done) checkVal("rdData", rd_data[r], q[idx].data);
        end
      end
    end
    for (int k = 0; k < WIDTH; k++) begin
      checkVal("retireValid", retire_valid[k], mRetValid[k]);
      if (mRetValid[k]) begin
        checkVal("retireDst", retire_dst[k], mRetDst[k]);
        checkVal("retireData", retire_data[k], mRetData[k]);
        checkVal("retirePc", retire_pc[k], mRetPc[k]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (checking) checkOutput();
  end

  task automatic clearInputs();
    reset       = 1'b0;
    flush       = 1'b0;
    alloc_valid = '0;
    alloc_dst   = '0;
    alloc_pc    = '0;
    wb_valid    = '0;
    wb_id       = '0;
    wb_data     = '0;
    rd_id       = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(logic [1:0] av, logic [1:0] wv, int id0, logic [63:0] d0,
                               int id1, logic [63:0] d1);
    alloc_valid  = av;
    alloc_dst[0] = 5'($urandom_range(0, 31));
    alloc_dst[1] = 5'($urandom_range(0, 31));
    alloc_pc[0]  = {$urandom, $urandom};
    alloc_pc[1]  = {$urandom, $urandom};
    wb_valid     = wv;
    wb_id[0]     = ID_W'(id0);
    wb_id[1]     = ID_W'(id1);
    wb_data[0]   = d0;
    wb_data[1]   = d1;
  endtask

  int guard;

  initial begin
    clearInputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checking = 1'b1;
    #1;
    checkVal("rstCount", count, 0);
    checkVal("rstReady", alloc_ready, 1);
    checkVal("rstRetValid", retire_valid, 0);
    checkVal("rstRetData", retire_data[0], 0);

    // In-order commit: the younger entry finishes first but must wait for the older one.
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 0);
    #1;
    checkVal("ioAllocId0", alloc_id[0], 0);
    checkVal("ioAllocId1", alloc_id[1], 1);
    cycle();
    applyStimulus(2'b00, 2'b01, 1, 64'hB, 0, 0);
    cycle();
    checkVal("ioNoRetire1", retire_valid, 0);
    applyStimulus(2'b00, 2'b01, 0, 64'hA, 0, 0);
    cycle();
    checkVal("ioNoRetire2", retire_valid, 0);
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
    cycle();
    checkVal("ioRetValid", retire_valid, 2'b11);
    checkVal("ioRetData0", retire_data[0], 64'hA);
    checkVal("ioRetData1", retire_data[1], 64'hB);
    cycle();
    checkVal("ioRetOnce", retire_valid, 0);
    checkVal("ioCount", count, 0);

    // Read bypass on id 3, then flush a six-entry buffer while allocating.
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 0);
    cycle();
    applyStimulus(2'b00, 2'b01, 3, 64'h55, 0, 0);
    rd_id[0] = 4'd3;
    #1;
    checkVal("bypassDone", rd_done[0], 1);
    checkVal("bypassData", rd_data[0], 64'h55);
    cycle();
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 0);
    cycle();
    cycle();
    checkVal("preFlushCount", count, 6);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    checkVal("flushCount", count, 0);
    checkVal("flushRetValid", retire_valid, 0);
    checkVal("flushTail", alloc_id[0], 0);
    clearInputs();

    // Fill to capacity; the extra allocate must be dropped.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b11, 2'b00, 0, 0, 0, 0);
      cycle();
    end
    checkVal("fullCount", count, 16);
    checkVal("fullReady", alloc_ready, 0);
    cycle();
    #1;
    checkVal("fullCountHold", count, 16);
    checkVal("fullTailHold", alloc_id[0], 0);

    // Commit one while a blocked single-lane allocate is presented at count 15.
    applyStimulus(2'b00, 2'b01, 0, 64'h100, 0, 0);
    cycle();
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
    cycle();
    checkVal("simRet1", retire_valid, 2'b01);
    checkVal("simCount15", count, 15);
    applyStimulus(2'b01, 2'b01, 1, 64'h101, 0, 0);
    #1;
    checkVal("simReady15", alloc_ready, 0);
    cycle();
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 0);
    #1;
    checkVal("simReadyStill", alloc_ready, 0);
    cycle();
    checkVal("simRet2", retire_valid, 2'b01);
    checkVal("simRetData", retire_data[0], 64'h101);
    checkVal("simCount14", count, 14);
    checkVal("simReady14", alloc_ready, 1);
    clearInputs();
    flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Walk head and tail to 15, then allocate across the wrap.
    for (int i = 0; i < 8; i++) begin
      applyStimulus((i == 7) ? 2'b01 : 2'b11, 2'b00, 0, 0, 0, 0);
      cycle();
    end
    for (int i = 0; i < 15; i += 2) begin
      applyStimulus(2'b00, (i + 1 < 15) ? 2'b11 : 2'b01, i, 64'(i + 16), i + 1, 64'(i + 17));
      cycle();
    end
    clearInputs();
    guard = 0;
    while (count != 0 && guard < 40) begin
      cycle();
      guard++;
    end
    checkVal("wrapDrained", count, 0);
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 0);
    #1;
    checkVal("wrapId0", alloc_id[0], 15);
    checkVal("wrapId1", alloc_id[1], 0);
    cycle();
    applyStimulus(2'b00, 2'b11, 15, 64'hF15, 0, 64'hF00);
    cycle();
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 0);
    cycle();
    checkVal("wrapRetValid", retire_valid, 2'b11);
    checkVal("wrapRetData0", retire_data[0], 64'hF15);
    checkVal("wrapCount", count, 0);
    alloc_valid = 2'b01;
    #1;
    checkVal("wrapHead", alloc_id[0], 1);
    clearInputs();

    // Randomized traffic; writebacks and reads mostly target live entries.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 79) == 0);
      applyStimulus(2'($urandom_range(0, 3)), 2'b00, 0, 0, 0, 0);
      for (int p = 0; p < 2; p++) begin
        wb_valid[p] = ($urandom_range(0, 2) != 0);
        wb_id[p]    = (q.size() > 0 && $urandom_range(0, 3) != 0) ?
                      ID_W'(q[$urandom_range(0, q.size() - 1)].id) : ID_W'($urandom_range(0, 15));
        wb_data[p]  = {$urandom, $urandom};
      end
      for (int r = 0; r < 4; r++)
        rd_id[r] = (q.size() > 0 && $urandom_range(0, 1) != 0) ?
                   ID_W'(q[$urandom_range(0, q.size() - 1)].id) : ID_W'($urandom_range(0, 15));
      cycle();
    end
    clearInputs();
    cycle();
    checking = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
